mem_op_arbiter: RTL and testbench
=================================

// Module: mem_op_arbiter
// PURPOSE
// Merges three request streams (display-controller reads, coherence retries from the resend queue,
// core/ring memory ops) into the single memOp queue + writeData queue consumed by the coherent
// memory FSM. Fixed priority with anti-starvation for core ops; flushes forwarded atomically
// with their write-data beats, so op/data pairing in the downstream queues is never interleaved.
// PARAMETERS
// STARVE_LIMIT  8   consecutive lost arbitrations after which a waiting core op wins once
// WD_BEATS      2   128-bit write-data beats per flush (one 32-byte cache line)
// CNT_W         16  width of saturating per-source grant counters
// PORTS
// clock          in   1    system clock
// reset          in   1    synchronous, active-high
// dcEmpty        in   1    display-controller request FIFO empty (first-word-fall-through)
// rdDC           out  1    pop DC request
// dcAddr         in   26   DC read line address
// rsEmpty        in   1    resend FIFO empty (FWFT)
// rdRS           out  1    pop resend entry
// rsIn           in   40   {dest[3:0], type[3:0], data[31:0]}; only dest and data are used
// coreEmpty      in   1    core op FIFO empty (FWFT)
// rdCore         out  1    pop core op
// coreDest       in   4    core op destination (never 0)
// coreData       in   32   core op word; bit28=1 read/excl-read, bit28=0 flush
// coreWdEmpty    in   1    core write-data FIFO empty (FWFT)
// rdCoreWd       out  1    pop core write-data beat
// coreWdIn       in   128  core write-data beat
// memOpQfull     in   1    downstream memOp queue full
// wrMemOp        out  1    push to memOp queue
// memOpOut       out  36   {dest[3:0], data[31:0]}
// writeDataQfull in   1    downstream writeData queue full
// wrWriteData    out  1    push to writeData queue
// writeDataOut   out  128  write-data beat
// grantCntDC/RS/Core out CNT_W each  saturating grant counters (debug)
// BEHAVIOUR
// - Reset, sync active-high: reset and clock as stated above. state=ARB, starveCnt=0,
//   beatCnt=0, all grant counters 0. All pop/push strobes and data outputs are 0 whenever no
//   transfer occurs.
// - Strobes and data are combinational from the current state and inputs (FWFT). A grant pops
//   the source and pushes memOp in the same cycle, so latency is 0 cycles.
// - ARB: no grant while memOpQfull. Candidate set: dc=~dcEmpty, rs=~rsEmpty,
//   core=~coreEmpty & (coreData[28] | ~writeDataQfull).
//   Priority: core if starveCnt==STARVE_LIMIT, else dc > rs > core.
//   DC grant: memOpOut={4'h0, 6'b0, dcAddr}.
//   RS grant: memOpOut={rsIn[39:36], rsIn[31:0]}.
//   Core grant: memOpOut={coreDest, coreData}. If coreData[28]==0, next state is FLUSH and
//   beatCnt=0.
// - starveCnt: cleared on any core grant. Incremented, saturating at STARVE_LIMIT, when core is
//   a candidate and another source is granted. Held otherwise.
// - FLUSH: no memOp grants. When ~coreWdEmpty & ~writeDataQfull, assert rdCoreWd and
//   wrWriteData with writeDataOut=coreWdIn, and increment beatCnt. On beat WD_BEATS-1, return
//   to ARB. Stalls indefinitely on an empty or full queue; there is no timeout.
// - The op is pushed before its data, which is legal because the memory FSM waits on
//   writeDataQempty.
// - Grant counters increment on the matching grant and saturate at all-ones.
// - Reset during FLUSH: return to ARB and drop the partially sent beats. The system-wide reset
//   clears the downstream queues too.
// - Simultaneous all-valid with starveCnt<LIMIT: DC wins. DC with memOpQfull: nothing granted,
//   and starveCnt is unchanged.
// STRUCTURE
// - Shared package mem_op_pkg: MEMOP_W=36, RESEND_W=40, WD_W=128, field offsets (dest, type,
//   RD/flush bit 28, retry bit 31), DC_DEST=4'h0, arb state enum {ARB, FLUSH}.
// - One natural sub-module: sat_counter (CNT_W, inc, clear), used for starveCnt and the three
//   grant counters.
// TESTING
// 1 dc, rs and core read all valid, queues empty -> cycle0 DC, cycle1 RS, cycle2 core;
//   memOpOut matches each source.
// 2 rs continuously valid, core read valid -> core granted on the 9th arbitration
//   (STARVE_LIMIT=8); starveCnt returns to 0.
// 3 core flush 0x0000_1240 with two beats A, B, and rs valid throughout -> memOp, then A, then
//   B; no rs grant until after B.
// 4 Flush with coreWdEmpty held 5 cycles after beat A -> FSM holds FLUSH, no grants, B
//   forwarded once available.
// 5 memOpQfull=1 with all sources valid for 10 cycles -> no strobes, counters unchanged;
//   release -> DC grant.
// 6 Assert reset after beat A of a flush -> all outputs 0 next cycle, state ARB, grant
//   counters 0.

Source files
------------

// File: rtl/mem_op_pkg.sv
// Shared types and constants for the memory-op arbiter slice.
// Holds bus widths, field offsets of the resend / core op words,
// the memOp payload struct and the arbiter state encoding.
package mem_op_pkg;

    localparam int unsigned DEST_W    = 4;
    localparam int unsigned TYPE_W    = 4;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DC_ADDR_W = 26;

    localparam int unsigned MEMOP_W  = 36;
    localparam int unsigned RESEND_W = 40;
    localparam int unsigned WD_W     = 128;

    // Field offsets within the resend word and the core/memOp data word
    localparam int unsigned RS_DEST_LSB = 36;
    localparam int unsigned RS_TYPE_LSB = 32;
    localparam int unsigned RD_BIT      = 28;
    localparam int unsigned RETRY_BIT   = 31;

    localparam logic [DEST_W-1:0] DC_DEST = 4'h0;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } mem_op_t;

    typedef enum logic {
        ARB   = 1'b0,
        FLUSH = 1'b1
    } arb_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports: clock, reset (sync, active-high), inc (count up), clear (to zero,
// wins over inc), count (current value, sticks at MAX).
module sat_counter #(
    parameter int unsigned W   = 16,
    parameter logic [W-1:0] MAX = '1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] count
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != MAX)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/mem_op_arbiter.sv
// Merges display-controller reads, resend-queue retries and core ops into
// the single memOp queue and writeData queue feeding the coherent memory FSM.
// Fixed priority dc > rs > core, with a starved core op winning once. A core
// flush is followed by its WD_BEATS write-data beats before any further
// memOp grant, so op/data pairs are never interleaved downstream.
// Ports: FWFT source FIFOs (dc*, rs*, core*, coreWd*) with pop strobes
// rdDC/rdRS/rdCore/rdCoreWd; downstream push wrMemOp/memOpOut and
// wrWriteData/writeDataOut gated by the *Qfull flags; grantCnt* debug counters.
// All strobes and data are combinational (zero-latency grant).
module mem_op_arbiter
    import mem_op_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 8,
    parameter int unsigned WD_BEATS     = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 dcEmpty,
    output logic                 rdDC,
    input  logic [DC_ADDR_W-1:0] dcAddr,
    input  logic                 rsEmpty,
    output logic                 rdRS,
    input  logic [RESEND_W-1:0]  rsIn,
    input  logic                 coreEmpty,
    output logic                 rdCore,
    input  logic [DEST_W-1:0]    coreDest,
    input  logic [DATA_W-1:0]    coreData,
    input  logic                 coreWdEmpty,
    output logic                 rdCoreWd,
    input  logic [WD_W-1:0]      coreWdIn,
    input  logic                 memOpQfull,
    output logic                 wrMemOp,
    output logic [MEMOP_W-1:0]   memOpOut,
    input  logic                 writeDataQfull,
    output logic                 wrWriteData,
    output logic [WD_W-1:0]      writeDataOut,
    output logic [CNT_W-1:0]     grantCntDC,
    output logic [CNT_W-1:0]     grantCntRS,
    output logic [CNT_W-1:0]     grantCntCore
);

    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int unsigned BEAT_W   = (WD_BEATS > 1) ? $clog2(WD_BEATS) : 1;

    arb_state_e          state_q, state_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [STARVE_W-1:0] starve_cnt;
    logic                dc_cand, rs_cand, core_cand;
    logic                grant_dc, grant_rs, grant_core;
    mem_op_t             op;

    // Type field of resend entries and the retry bit are carried but not acted on
    logic [TYPE_W-1:0] unused_rs_type;
    logic              unused_retry;
    assign unused_rs_type = rsIn[RS_TYPE_LSB +: TYPE_W];
    assign unused_retry   = coreData[RETRY_BIT];

    // A flush can only be granted when its first beat has room downstream
    assign dc_cand   = ~dcEmpty;
    assign rs_cand   = ~rsEmpty;
    assign core_cand = ~coreEmpty & (coreData[RD_BIT] | ~writeDataQfull);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ARB;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // Next state, grants and write-data forwarding; everything idles during reset
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        grant_dc     = 1'b0;
        grant_rs     = 1'b0;
        grant_core   = 1'b0;
        rdCoreWd     = 1'b0;
        wrWriteData  = 1'b0;
        writeDataOut = '0;
        op           = '0;
        case (state_q)
            ARB: begin
                if (!reset && !memOpQfull) begin
                    if (core_cand && (starve_cnt == STARVE_W'(STARVE_LIMIT))) begin
                        grant_core = 1'b1;
                    end else if (dc_cand) begin
                        grant_dc = 1'b1;
                    end else if (rs_cand) begin
                        grant_rs = 1'b1;
                    end else if (core_cand) begin
                        grant_core = 1'b1;
                    end
                end
                if (grant_dc) begin
                    op.dest = DC_DEST;
                    op.data = DATA_W'(dcAddr);
                end else if (grant_rs) begin
                    op.dest = rsIn[RS_DEST_LSB +: DEST_W];
                    op.data = rsIn[DATA_W-1:0];
                end else if (grant_core) begin
                    op.dest = coreDest;
                    op.data = coreData;
                    if (!coreData[RD_BIT]) begin
                        state_d = FLUSH;
                        beat_d  = '0;
                    end
                end
            end
            FLUSH: begin
                if (!reset && !coreWdEmpty && !writeDataQfull) begin
                    rdCoreWd     = 1'b1;
                    wrWriteData  = 1'b1;
                    writeDataOut = coreWdIn;
                    if (beat_q == BEAT_W'(WD_BEATS - 1)) begin
                        state_d = ARB;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    assign rdDC     = grant_dc;
    assign rdRS     = grant_rs;
    assign rdCore   = grant_core;
    assign wrMemOp  = grant_dc | grant_rs | grant_core;
    assign memOpOut = op;

    // Core loses an arbitration only when it was eligible and someone else won
    sat_counter #(.W(STARVE_W), .MAX(STARVE_W'(STARVE_LIMIT))) u_starve (
        .clock (clock),
        .reset (reset),
        .inc   (core_cand & (grant_dc | grant_rs)),
        .clear (grant_core),
        .count (starve_cnt)
    );

    sat_counter #(.W(CNT_W)) u_cnt_dc (
        .clock (clock),
        .reset (reset),
        .inc   (grant_dc),
        .clear (1'b0),
        .count (grantCntDC)
    );

    sat_counter #(.W(CNT_W)) u_cnt_rs (
        .clock (clock),
        .reset (reset),
        .inc   (grant_rs),
        .clear (1'b0),
        .count (grantCntRS)
    );

    sat_counter #(.W(CNT_W)) u_cnt_core (
        .clock (clock),
        .reset (reset),
        .inc   (grant_core),
        .clear (1'b0),
        .count (grantCntCore)
    );

endmodule

// File: tb/tb_mem_op_arbiter.sv
// Self-checking bench for mem_op_arbiter: scenario tasks drive FWFT sources,
// a scoreboard holds expected memOp / write-data words in issue order.
module tb_mem_op_arbiter;
    import mem_op_pkg::*;

    localparam int unsigned CNT_W = 16;

    // Strobe vector order: {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData}
    localparam logic [5:0] S_DC   = 6'b100010;
    localparam logic [5:0] S_RS   = 6'b010010;
    localparam logic [5:0] S_CORE = 6'b001010;
    localparam logic [5:0] S_BEAT = 6'b000101;
    localparam logic [5:0] S_NONE = 6'b000000;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 dcEmpty, rdDC;
    logic [DC_ADDR_W-1:0] dcAddr;
    logic                 rsEmpty, rdRS;
    logic [RESEND_W-1:0]  rsIn;
    logic                 coreEmpty, rdCore;
    logic [DEST_W-1:0]    coreDest;
    logic [DATA_W-1:0]    coreData;
    logic                 coreWdEmpty, rdCoreWd;
    logic [WD_W-1:0]      coreWdIn;
    logic                 memOpQfull, wrMemOp;
    logic [MEMOP_W-1:0]   memOpOut;
    logic                 writeDataQfull, wrWriteData;
    logic [WD_W-1:0]      writeDataOut;
    logic [CNT_W-1:0]     grantCntDC, grantCntRS, grantCntCore;

    logic [MEMOP_W-1:0] exp_op_q[$];
    logic [WD_W-1:0]    exp_wd_q[$];
    logic [MEMOP_W-1:0] mon_op;
    logic [WD_W-1:0]    mon_wd;
    int n_checks = 0;
    int n_pass   = 0;
    int exp_dc = 0, exp_rs = 0, exp_core = 0;

    localparam logic [WD_W-1:0] BEAT_A = {4{32'hAAAA_0001}};
    localparam logic [WD_W-1:0] BEAT_B = {4{32'hBBBB_0002}};
    localparam logic [WD_W-1:0] BEAT_C = {4{32'hCCCC_0003}};
    localparam logic [WD_W-1:0] BEAT_D = {4{32'hDDDD_0004}};
    localparam logic [WD_W-1:0] BEAT_E = {4{32'hEEEE_0005}};
    localparam logic [WD_W-1:0] BEAT_F = {4{32'hFFFF_0006}};

    mem_op_arbiter #(.STARVE_LIMIT(8), .WD_BEATS(2), .CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .dcEmpty        (dcEmpty),
        .rdDC           (rdDC),
        .dcAddr         (dcAddr),
        .rsEmpty        (rsEmpty),
        .rdRS           (rdRS),
        .rsIn           (rsIn),
        .coreEmpty      (coreEmpty),
        .rdCore         (rdCore),
        .coreDest       (coreDest),
        .coreData       (coreData),
        .coreWdEmpty    (coreWdEmpty),
        .rdCoreWd       (rdCoreWd),
        .coreWdIn       (coreWdIn),
        .memOpQfull     (memOpQfull),
        .wrMemOp        (wrMemOp),
        .memOpOut       (memOpOut),
        .writeDataQfull (writeDataQfull),
        .wrWriteData    (wrWriteData),
        .writeDataOut   (writeDataOut),
        .grantCntDC     (grantCntDC),
        .grantCntRS     (grantCntRS),
        .grantCntCore   (grantCntCore)
    );

    always #5 clock = ~clock;

    // Scoreboard: every downstream push must match the oldest expected word
    always @(negedge clock) begin
        if (!reset && wrMemOp) begin
            if (exp_op_q.size() != 0) mon_op = exp_op_q.pop_front();
            else mon_op = 'x;
            n_checks++;
            if (memOpOut !== mon_op)
                $display("FAIL memop_sb: got %h required %h", memOpOut, mon_op);
            else n_pass++;
        end
        if (!reset && wrWriteData) begin
            if (exp_wd_q.size() != 0) mon_wd = exp_wd_q.pop_front();
            else mon_wd = 'x;
            n_checks++;
            if (writeDataOut !== mon_wd)
                $display("FAIL wdata_sb: got %h required %h", writeDataOut, mon_wd);
            else n_pass++;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [MEMOP_W-1:0] dc_op();
        return {DC_DEST, 6'b0, dcAddr};
    endfunction

    function automatic logic [MEMOP_W-1:0] rs_op();
        return {rsIn[39:36], rsIn[31:0]};
    endfunction

    function automatic logic [MEMOP_W-1:0] core_op();
        return {coreDest, coreData};
    endfunction

    task automatic test_reset();
        // Sources valid while reset is held: nothing may be popped
        reset = 1'b1; dcEmpty = 1'b0; rsEmpty = 1'b0; coreEmpty = 1'b0;
        coreData = 32'h1000_0000;
        @(negedge clock);
        n_checks++;
        if ({rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData} !== S_NONE)
            $display("FAIL reset_strobes: got %b required %b",
                     {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData}, S_NONE);
        else n_pass++;
        tick();
        dcEmpty = 1'b1; rsEmpty = 1'b1; coreEmpty = 1'b1; reset = 1'b0;
        @(negedge clock);
        n_checks++;
        if ({memOpOut, writeDataOut} !== '0)
            $display("FAIL reset_data: got %h/%h required 0", memOpOut, writeDataOut);
        else n_pass++;
        n_checks++;
        if ({grantCntDC, grantCntRS, grantCntCore} !== '0)
            $display("FAIL reset_cnt: got %0d/%0d/%0d required 0/0/0",
                     grantCntDC, grantCntRS, grantCntCore);
        else n_pass++;
        tick();
    endtask

    task automatic test_priority();
        logic [5:0] got;
        logic [5:0] want[3];
        want[0] = S_DC; want[1] = S_RS; want[2] = S_CORE;
        dcAddr = 26'h2AB_CDEF; rsIn = {4'h5, 4'h3, 32'h8000_0042};
        coreDest = 4'h7; coreData = 32'h1000_0100;
        dcEmpty = 1'b0; rsEmpty = 1'b0; coreEmpty = 1'b0;
        exp_op_q.push_back(dc_op());
        exp_op_q.push_back(rs_op());
        exp_op_q.push_back(core_op());
        exp_dc++; exp_rs++; exp_core++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            got = {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData};
            n_checks++;
            if (got !== want[i])
                $display("FAIL prio_cycle%0d: got %b required %b", i, got, want[i]);
            else n_pass++;
            tick();
            if (got[5]) dcEmpty = 1'b1;
            if (got[4]) rsEmpty = 1'b1;
            if (got[3]) coreEmpty = 1'b1;
        end
        @(negedge clock);
        n_checks++;
        if ({grantCntDC, grantCntRS, grantCntCore} !== {CNT_W'(exp_dc), CNT_W'(exp_rs), CNT_W'(exp_core)})
            $display("FAIL prio_cnt: got %0d/%0d/%0d required %0d/%0d/%0d",
                     grantCntDC, grantCntRS, grantCntCore, exp_dc, exp_rs, exp_core);
        else n_pass++;
        tick();
    endtask

    task automatic test_starvation();
        logic [5:0] want;
        rsIn = {4'h2, 4'h1, 32'h0000_0300}; rsEmpty = 1'b0;
        coreDest = 4'h9; coreData = 32'h1000_0400; coreEmpty = 1'b0;
        // Two rounds: the second shows the starve count restarted from zero
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 9; i++) begin
                want = (i == 8) ? S_CORE : S_RS;
                exp_op_q.push_back((i == 8) ? core_op() : rs_op());
                if (i == 8) exp_core++; else exp_rs++;
                @(negedge clock);
                n_checks++;
                if ({rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData} !== want)
                    $display("FAIL starve_r%0d_arb%0d: got %b required %b", r, i + 1,
                             {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData}, want);
                else n_pass++;
                tick();
            end
        end
        rsEmpty = 1'b1; coreEmpty = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({grantCntRS, grantCntCore} !== {CNT_W'(exp_rs), CNT_W'(exp_core)})
            $display("FAIL starve_cnt: got %0d/%0d required %0d/%0d",
                     grantCntRS, grantCntCore, exp_rs, exp_core);
        else n_pass++;
        tick();
    endtask

    task automatic test_flush_atomic();
        logic [5:0] got, want;
        rsIn = {4'h3, 4'h0, 32'h0000_0500}; rsEmpty = 1'b0;
        coreDest = 4'h4; coreData = 32'h0000_1240; coreEmpty = 1'b0;
        coreWdIn = BEAT_A; coreWdEmpty = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i < 8 || i == 11) want = S_RS;
            else if (i == 8) want = S_CORE;
            else want = S_BEAT;
            if (want == S_RS) begin exp_op_q.push_back(rs_op()); exp_rs++; end
            if (want == S_CORE) begin exp_op_q.push_back(core_op()); exp_core++; end
            if (want == S_BEAT) exp_wd_q.push_back(coreWdIn);
            @(negedge clock);
            got = {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData};
            n_checks++;
            if (got !== want)
                $display("FAIL flush_cycle%0d: got %b required %b", i, got, want);
            else n_pass++;
            tick();
            if (got[3]) coreEmpty = 1'b1;
            if (got[2]) begin
                if (coreWdIn == BEAT_A) coreWdIn = BEAT_B;
                else coreWdEmpty = 1'b1;
            end
        end
        rsEmpty = 1'b1; coreWdEmpty = 1'b1;
    endtask

    task automatic test_flush_stall();
        logic [5:0] got, want;
        rsEmpty = 1'b1;
        coreDest = 4'h8; coreData = 32'h0000_2280; coreEmpty = 1'b0;
        coreWdIn = BEAT_C; coreWdEmpty = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (i == 0) want = S_CORE;
            else if (i == 1 || i == 7) want = S_BEAT;
            else if (i == 8) want = S_RS;
            else want = S_NONE;
            if (want == S_RS) begin exp_op_q.push_back(rs_op()); exp_rs++; end
            if (want == S_CORE) begin exp_op_q.push_back(core_op()); exp_core++; end
            if (want == S_BEAT) exp_wd_q.push_back(coreWdIn);
            @(negedge clock);
            got = {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData};
            n_checks++;
            if (got !== want)
                $display("FAIL stall_cycle%0d: got %b required %b", i, got, want);
            else n_pass++;
            tick();
            if (i == 0) begin
                coreEmpty = 1'b1;
                rsEmpty = 1'b0; rsIn = {4'h1, 4'h2, 32'h0000_0700};
            end
            if (i == 1) coreWdEmpty = 1'b1;
            if (i == 6) begin coreWdEmpty = 1'b0; coreWdIn = BEAT_D; end
            if (i == 7) coreWdEmpty = 1'b1;
        end
        rsEmpty = 1'b1;
    endtask

    task automatic test_qfull();
        logic [5:0] got;
        memOpQfull = 1'b1;
        dcAddr = 26'h000_0123; dcEmpty = 1'b0;
        rsIn = {4'h2, 4'h2, 32'h0000_0900}; rsEmpty = 1'b0;
        coreDest = 4'h3; coreData = 32'h1000_0A00; coreEmpty = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            got = {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData};
            n_checks++;
            if (got !== S_NONE || memOpOut !== '0)
                $display("FAIL qfull_cycle%0d: got %b/%h required %b/0", i, got, memOpOut, S_NONE);
            else n_pass++;
            tick();
        end
        @(negedge clock);
        n_checks++;
        if ({grantCntDC, grantCntRS, grantCntCore} !== {CNT_W'(exp_dc), CNT_W'(exp_rs), CNT_W'(exp_core)})
            $display("FAIL qfull_cnt: got %0d/%0d/%0d required %0d/%0d/%0d",
                     grantCntDC, grantCntRS, grantCntCore, exp_dc, exp_rs, exp_core);
        else n_pass++;
        tick();
        memOpQfull = 1'b0;
        exp_op_q.push_back(dc_op()); exp_dc++;
        @(negedge clock);
        got = {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData};
        n_checks++;
        if (got !== S_DC)
            $display("FAIL qfull_release: got %b required %b", got, S_DC);
        else n_pass++;
        tick();
        dcEmpty = 1'b1; rsEmpty = 1'b1; coreEmpty = 1'b1;
        @(negedge clock);
        n_checks++;
        if (grantCntDC !== CNT_W'(exp_dc))
            $display("FAIL qfull_dc_cnt: got %0d required %0d", grantCntDC, exp_dc);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_flush();
        logic [5:0] got;
        coreDest = 4'h6; coreData = 32'h0000_3300; coreEmpty = 1'b0;
        coreWdIn = BEAT_E; coreWdEmpty = 1'b0;
        exp_op_q.push_back(core_op()); exp_core++;
        @(negedge clock);
        got = {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData};
        n_checks++;
        if (got !== S_CORE) $display("FAIL rstf_grant: got %b required %b", got, S_CORE);
        else n_pass++;
        tick();
        coreEmpty = 1'b1;
        exp_wd_q.push_back(coreWdIn);
        @(negedge clock);
        got = {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData};
        n_checks++;
        if (got !== S_BEAT) $display("FAIL rstf_beat_a: got %b required %b", got, S_BEAT);
        else n_pass++;
        tick();
        // Beat B is waiting but reset drops the rest of the flush
        coreWdIn = BEAT_F; reset = 1'b1;
        @(negedge clock);
        got = {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData};
        n_checks++;
        if (got !== S_NONE || writeDataOut !== '0)
            $display("FAIL rstf_in_reset: got %b/%h required %b/0", got, writeDataOut, S_NONE);
        else n_pass++;
        tick();
        reset = 1'b0;
        exp_dc = 0; exp_rs = 0; exp_core = 0;
        @(negedge clock);
        got = {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData};
        n_checks++;
        if (got !== S_NONE) $display("FAIL rstf_after: got %b required %b", got, S_NONE);
        else n_pass++;
        n_checks++;
        if ({grantCntDC, grantCntRS, grantCntCore} !== '0)
            $display("FAIL rstf_cnt: got %0d/%0d/%0d required 0/0/0",
                     grantCntDC, grantCntRS, grantCntCore);
        else n_pass++;
        tick();
        // Back in ARB: a core read is granted straight away
        coreWdEmpty = 1'b1;
        coreData = 32'h1000_0600; coreEmpty = 1'b0;
        exp_op_q.push_back(core_op()); exp_core++;
        @(negedge clock);
        got = {rdDC, rdRS, rdCore, rdCoreWd, wrMemOp, wrWriteData};
        n_checks++;
        if (got !== S_CORE) $display("FAIL rstf_arb_grant: got %b required %b", got, S_CORE);
        else n_pass++;
        tick();
        coreEmpty = 1'b1;
        @(negedge clock);
        n_checks++;
        if (grantCntCore !== CNT_W'(exp_core))
            $display("FAIL rstf_core_cnt: got %0d required %0d", grantCntCore, exp_core);
        else n_pass++;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        dcEmpty = 1'b1; dcAddr = '0;
        rsEmpty = 1'b1; rsIn = '0;
        coreEmpty = 1'b1; coreDest = 4'h1; coreData = '0;
        coreWdEmpty = 1'b1; coreWdIn = '0;
        memOpQfull = 1'b0; writeDataQfull = 1'b0;
        tick();
        test_reset();
        test_priority();
        test_starvation();
        test_flush_atomic();
        test_flush_stall();
        test_qfull();
        test_reset_flush();
        @(negedge clock);
        n_checks++;
        if (exp_op_q.size() != 0)
            $display("FAIL memop_leftover: got %0d pending required 0", exp_op_q.size());
        else n_pass++;
        n_checks++;
        if (exp_wd_q.size() != 0)
            $display("FAIL wdata_leftover: got %0d pending required 0", exp_wd_q.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
